// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light sequence monitor: phases, LED patterns, error codes.
package traffic_pkg;

  typedef enum logic [2:0] {
    PhNone    = 3'd0,
    PhMg      = 3'd1,
    PhMy      = 3'd2,
    PhSg      = 3'd3,
    PhSy      = 3'd4,
    PhWalk    = 3'd5,
    PhIllegal = 3'd6
  } phase_e;

  // LED bit order: Main_Red, Main_Yellow, Main_Green, Side_Red, Side_Yellow, Side_Green, Walk
  localparam logic [6:0] LedMg   = 7'b0011000;
  localparam logic [6:0] LedMy   = 7'b0101000;
  localparam logic [6:0] LedSg   = 7'b1000010;
  localparam logic [6:0] LedSy   = 7'b1000100;
  localparam logic [6:0] LedWalk = 7'b1001001;

  localparam logic [1:0] ErrNone       = 2'b00;
  localparam logic [1:0] ErrPattern    = 2'b01;
  localparam logic [1:0] ErrTransition = 2'b10;
  localparam logic [1:0] ErrYellow     = 2'b11;

  // True when moving from 'from_ph' to a legal 'to_ph' follows the controller's cycle.
  function automatic logic legal_transition(phase_e from_ph, phase_e to_ph);
    logic ok;
    ok = 1'b0;
    case (from_ph)
      PhNone:    ok = (to_ph == PhMg);
      PhMg:      ok = (to_ph == PhMy);
      PhMy:      ok = (to_ph == PhSg) || (to_ph == PhWalk);
      PhWalk:    ok = (to_ph == PhSg);
      PhSg:      ok = (to_ph == PhSy);
      PhSy:      ok = (to_ph == PhMg);
      PhIllegal: ok = (to_ph != PhIllegal) && (to_ph != PhNone);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/led_phase_decode.sv
// Combinational LED pattern to phase decoder; anything unrecognised is ILLEGAL.
module led_phase_decode
  import traffic_pkg::*;
(
  input  logic [6:0] leds_i,
  output phase_e     phase_o
);

  // Exact-match decode of the five legal light patterns
  always_comb begin
    phase_o = PhIllegal;
    unique case (leds_i)
      LedMg:   phase_o = PhMg;
      LedMy:   phase_o = PhMy;
      LedSg:   phase_o = PhSg;
      LedSy:   phase_o = PhSy;
      LedWalk: phase_o = PhWalk;
      default: phase_o = PhIllegal;
    endcase
  end

endmodule

// File: rtl/led_sequence_monitor.sv
// Watches traffic controller LEDs, debounces them into phases, times each phase and
// latches the first sequencing error seen.
module led_sequence_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter logic [3:0]  MAX_YELLOW    = 4'd6
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [6:0] LEDs,
  input  logic       oneHz_enable,
  input  logic       Clear_Error,
  output logic [2:0] Phase,
  output logic [3:0] Phase_Seconds,
  output logic [3:0] Last_Duration,
  output logic       Error,
  output logic [1:0] Error_Code,
  output logic [7:0] Walk_Count
);

  localparam logic [2:0] StableMax  = 3'(STABLE_CYCLES);
  localparam logic [2:0] StableLast = 3'(STABLE_CYCLES - 1);

  logic [6:0] led_q, led_d;
  logic [2:0] cnt_q, cnt_d;
  phase_e     phase_q, phase_d;
  logic [3:0] secs_q, secs_d;
  logic [3:0] last_q, last_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;
  logic [7:0] walk_q, walk_d;

  phase_e     dec_phase;
  logic       accept;
  logic [1:0] new_err;

  led_phase_decode u_decode (
    .leds_i  (led_q),
    .phase_o (dec_phase)
  );

  // Next-state: debounce, phase tracking, timing and sticky error capture
  always_comb begin
    led_d   = LEDs;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    secs_d  = secs_q;
    last_d  = last_q;
    err_d   = err_q;
    code_d  = code_q;
    walk_d  = walk_q;
    new_err = ErrNone;

    // The registered pattern counts as held once the input still matches it
    accept = (LEDs == led_q) && (cnt_q == StableLast);
    if (LEDs != led_q) begin
      cnt_d = 3'd0;
    end else if (cnt_q != StableMax) begin
      cnt_d = cnt_q + 3'd1;
    end

    if (accept && (dec_phase != phase_q)) begin
      // A phase change swallows any coincident tick
      phase_d = dec_phase;
      last_d  = secs_q;
      secs_d  = 4'd0;
      if (dec_phase == PhIllegal) begin
        new_err = ErrPattern;
      end else if (!legal_transition(phase_q, dec_phase)) begin
        new_err = ErrTransition;
      end
      if (dec_phase == PhWalk) begin
        walk_d = walk_q + 8'd1;
      end
    end else if (oneHz_enable) begin
      if (secs_q != 4'hF) begin
        secs_d = secs_q + 4'd1;
      end
      // Only the step from MAX_YELLOW to MAX_YELLOW+1 flags, so once per visit
      if (((phase_q == PhMy) || (phase_q == PhSy)) && (secs_q == MAX_YELLOW) &&
          (secs_q != 4'hF)) begin
        new_err = ErrYellow;
      end
    end

    // First error wins; a clear in the same cycle lets a fresh error through
    if ((new_err != ErrNone) && (!err_q || Clear_Error)) begin
      err_d  = 1'b1;
      code_d = new_err;
    end else if (Clear_Error) begin
      err_d  = 1'b0;
      code_d = ErrNone;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (Reset) begin
      led_q   <= 7'd0;
      cnt_q   <= 3'd0;
      phase_q <= PhNone;
      secs_q  <= 4'd0;
      last_q  <= 4'd0;
      err_q   <= 1'b0;
      code_q  <= ErrNone;
      walk_q  <= 8'd0;
    end else begin
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      secs_q  <= secs_d;
      last_q  <= last_d;
      err_q   <= err_d;
      code_q  <= code_d;
      walk_q  <= walk_d;
    end
  end

  assign Phase         = phase_q;
  assign Phase_Seconds = secs_q;
  assign Last_Duration = last_q;
  assign Error         = err_q;
  assign Error_Code    = code_q;
  assign Walk_Count    = walk_q;

endmodule

// File: doc/led_sequence_monitor.md
LED_SEQUENCE_MONITOR -- requirements
Module: led_sequence_monitor

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 2, meaning the consecutive identical clk samples of LEDs needed to accept a pattern (range 1..7).
REQ-002 The block SHALL have parameter MAX_YELLOW, default 4'd6, meaning the longest legal yellow phase in 1 Hz ticks.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port LEDs, input, 7 bits: the controller light outputs, bit 6 down to bit 0 = Main_Red, Main_Yellow, Main_Green, Side_Red, Side_Yellow, Side_Green, Walk.
REQ-006 The block SHALL have port oneHz_enable, input, 1 bit: a one-clk pulse per second.
REQ-007 The block SHALL have port Clear_Error, input, 1 bit: a one-clk pulse that clears the latched error.
REQ-008 The block SHALL have port Phase, output, 3 bits: the accepted phase, 0 NONE, 1 MG, 2 MY, 3 SG, 4 SY, 5 WALK, 6 ILLEGAL.
REQ-009 The block SHALL have port Phase_Seconds, output, 4 bits: the ticks elapsed in the current phase.
REQ-010 The block SHALL have port Last_Duration, output, 4 bits: the final Phase_Seconds of the previous phase.
REQ-011 The block SHALL have ports Error (1 bit), Error_Code (2 bits: 01 bad pattern, 10 bad transition, 11 yellow overrun) and Walk_Count (8 bits), all outputs.

Function
REQ-012 The block SHALL decode LEDs as follows: MG=7'b0011000, MY=7'b0101000, SG=7'b1000010, SY=7'b1000100, WALK=7'b1001001; any other value SHALL be ILLEGAL.
REQ-013 The block SHALL register LEDs once, then run a stability counter that restarts whenever the registered value changes.
REQ-014 The block SHALL accept a pattern when that counter reaches STABLE_CYCLES; Phase SHALL update exactly STABLE_CYCLES+1 clks after LEDs change and hold.
REQ-015 The block SHALL ignore a glitch shorter than STABLE_CYCLES clks, leaving Phase unchanged.
REQ-016 Acceptance of a pattern whose decode equals the current Phase SHALL be a no-op.
REQ-017 The legal transitions SHALL be: NONE->MG, MG->MY, MY->SG, MY->WALK, WALK->SG, SG->SY, SY->MG, and ILLEGAL->any legal phase.
REQ-018 Any other phase change SHALL raise code 10; entering ILLEGAL SHALL raise code 01 and not also code 10.
REQ-019 On each phase change, Last_Duration SHALL take Phase_Seconds and Phase_Seconds SHALL become 0; an oneHz_enable in that same cycle SHALL be dropped.
REQ-020 Otherwise, Phase_Seconds SHALL increment on oneHz_enable, saturating at 15.
REQ-021 While Phase is MY or SY, the cycle Phase_Seconds increments past MAX_YELLOW SHALL raise code 11, once per phase visit.
REQ-022 Error handling SHALL be sticky first-error-wins: the first error sets Error=1 and Error_Code; later errors are ignored until cleared.
REQ-023 Clear_Error SHALL zero Error and Error_Code next clk; if a new error occurs in the same cycle, the new error SHALL be latched instead.
REQ-024 Walk_Count SHALL increment on each accepted entry into WALK, wrapping 255->0.

Reset
REQ-025 While Reset is high at a clk edge, the block SHALL set Phase=NONE, Phase_Seconds=0, Last_Duration=0, Error=0, Error_Code=00 and Walk_Count=0, and clear the stability counter and LED register.
REQ-026 Reset asserted mid-phase SHALL discard all history; the first accepted pattern after reset SHALL be checked as a transition from NONE.

Structure
REQ-027 Shared package traffic_pkg SHALL hold the phase encoding, the five LED pattern constants and the error codes.
REQ-028 LED-to-phase decoding SHALL be one combinational sub-module, led_phase_decode; all sequential logic stays in led_sequence_monitor.

Verification
REQ-029 Bench scenario: after reset, drive MG, MY, SG, SY, MG, each held 10 clks with STABLE_CYCLES=2 -> Phase 1,2,3,4,1, each appearing 3 clks after the change; Error=0.
REQ-030 Bench scenario: from MG, pulse LEDs=SG for 1 clk then return to MG -> Phase stays 1, Error=0.
REQ-031 Bench scenario: from MG, jump to SG -> Error=1, Code=10; then Clear_Error while also entering ILLEGAL 7'b1111111 -> Error=1, Code=01.
REQ-032 Bench scenario: hold MY for 7 ticks -> Code=11 at the 7th tick; Phase_Seconds=7; on the change to SG, Last_Duration=7.
REQ-033 Bench scenario: hold MG for 20 ticks -> Phase_Seconds saturates at 15; oneHz_enable coincident with a phase change -> Phase_Seconds=0.
REQ-034 Bench scenario: 256 MY->WALK->SG->SY->MG cycles -> Walk_Count wraps to 0; Reset mid-WALK -> all outputs zero next clk.
